scan_driver: RTL
================

# scan_driver

Host-side sequencer that drives the two-phase scan chain pads (scan_phi, scan_phi_bar, scan_data_in, scan_load_chain, scan_load_chip) and collects scan_data_out. It sits directly upstream of the scan chain block. It turns one word-wide command into:
- an optional capture (load_chain),
- N shift bits with non-overlapping phases,
- an optional update (load_chip).

It then returns the bits shifted out as one response word.

## Interface
Parameters:
- CHAIN_MAX, 64: widest chain or transfer supported, in bits.
- LEN_W, $clog2(CHAIN_MAX+1): width of cmd_len.
- PHASE_CYC, 2: clk cycles each phase pulse (phi, phi_bar, load_chip) is high. Must be ≥1.
- GAP_CYC, 1: non-overlap gap in clk cycles. Must be ≥1.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  bit0 = capture (load_chain) before shifting; bit1 = update (load_chip) after shifting.
- cmd_len  in  LEN_W  number of bits to shift. Values above CHAIN_MAX are clamped to CHAIN_MAX.
- cmd_wdata  in  CHAIN_MAX  bits to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  CHAIN_MAX  bits shifted out, LSB first; bits at index ≥ len are 0.
- scan_phi, scan_phi_bar  out  1  master and slave latch enables; never high together.
- scan_data_in  out  1  serial data to the chain.
- scan_data_out  in  1  serial data from the chain (slave bit 0).
- scan_load_chain, scan_load_chip  out  1  load controls.

## Operation
- States: IDLE, CAPTURE, SHIFT, TAIL, UPDATE, RESP.
- Command handshake:
  - cmd_valid & cmd_ready latches op, the clamped length and wdata.
  - rsp_rdata is cleared on the same edge.
  - Next state is CAPTURE if op[0]=1, otherwise SHIFT.
- CAPTURE:
  - scan_load_chain is high for the whole state.
  - Sub-sequence: G, then P with phi high, then G, then P with phi_bar high, then G (G = GAP_CYC, P = PHASE_CYC).
  - Total 3G+2P cycles. load_chain falls on exit.
- SHIFT, one slot per bit k = 0..len-1. Each slot is G, P with phi high, G, P with phi_bar high (2G+2P cycles):
  - scan_data_in = wdata[k] from the first cycle of the slot.
  - scan_data_out is registered into rsp_rdata[k] on the last cycle of the slot's first gap.
  - If len=0, SHIFT is skipped.
- TAIL: G cycles with all scan outputs low and scan_data_in=0. Then go to UPDATE if op[1]=1, otherwise RESP.
- UPDATE: P cycles with scan_load_chip high, then G cycles low, then RESP.
- RESP:
  - rsp_valid is held high until rsp_ready; rsp_rdata is stable throughout.
  - On the handshake, go to IDLE. cmd_ready rises the following cycle.
- Only one command is outstanding at a time. cmd_valid is ignored outside IDLE.
- Chain bit order: the first bit shifted in lands in chain bit 0 after exactly len shifts. Capture-then-shift of len = chain length therefore reads the chain and writes the new word in a single pass.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (asynchronous) puts every output at 0, rsp_rdata at 0 and the state at IDLE. cmd_ready rises in the first cycle after reset deasserts.
- Latency from the accepting edge to rsp_valid high is op[0]·(3G+2P) + len·(2G+2P) + G + op[1]·(P+G) cycles.
- phi and phi_bar are separated by at least G low cycles. scan_data_in changes only while both phases are low.
- load_chip is never high while phi or phi_bar is high.
- load_chain is high at least G cycles before phi rises and at least G cycles after phi_bar falls.
- Reset asserted mid-operation:
  - All pad outputs drop to 0 immediately; no response is produced.
  - Chain contents are undefined.
  - The state returns to IDLE.
- If rsp_ready is already high when rsp_valid rises, the handshake completes in one cycle.

## Test plan
- Reset mid-SHIFT with phi high -> phi drops the same cycle; cmd_ready=1 one cycle after deassert; no rsp_valid.
- op=0, len=8, wdata=0xA5, P=2, G=1; bench chain model preloaded with 0x3C -> rsp_valid after 8·6+1=49 cycles; rdata=0x3C; model now holds 0xA5; load_chain and load_chip never asserted.
- op=3, len=8, wdata=0x5A; model chip registers 0x00, load values 0x81 -> latency 7+48+1+3=59 cycles; rdata=0x81; chip registers = 0x5A after the load_chip pulse.
- len=0, op=2 -> no phi pulses; a single 2-cycle load_chip pulse; rdata=0; latency 1+3=4.
- cmd_len=100 with CHAIN_MAX=64 -> exactly 64 phi pulses and 64 phi_bar pulses.
- rsp_ready held low 10 cycles -> rsp_valid and rdata stable, cmd_ready=0, and a second cmd_valid is not accepted until the cycle after the handshake.
- Assertion monitor throughout all runs:
  - phi&phi_bar is never high together.
  - At least 1 low cycle separates the phases.
  - scan_data_in never toggles while either phase is high.

Source files
------------

// File: rtl/scan_driver_if.sv
// scan_driver_if
//   Host-side command/response channel of the scan chain sequencer.
//   master : the host (offers commands, accepts responses)
//   slave  : scan_driver (accepts commands, offers responses)
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               bit0 = capture before shifting, bit1 = update after
//   cmd_len              number of bits to shift
//   cmd_wdata            bits to shift in, LSB first
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            bits shifted out, LSB first
interface scan_driver_if #(
  parameter int CHAIN_MAX = 64,
  parameter int LEN_W     = $clog2(CHAIN_MAX + 1)
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [LEN_W-1:0]     cmd_len;
  logic [CHAIN_MAX-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_MAX-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/scan_driver.sv
// scan_driver
//   Turns one word-wide command into an optional capture (load_chain),
//   len two-phase shift slots and an optional update (load_chip), then
//   returns the shifted-out bits as one response word.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   host              command/response channel (scan_driver_if.slave)
//   scan_phi          master latch enable
//   scan_phi_bar      slave latch enable
//   scan_data_in      serial data to the chain
//   scan_data_out     serial data from the chain (slave bit 0)
//   scan_load_chain   parallel capture into the chain
//   scan_load_chip    parallel update from the chain into chip registers
module scan_driver #(
  parameter int CHAIN_MAX = 64,
  parameter int LEN_W     = $clog2(CHAIN_MAX + 1),
  parameter int PHASE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic         clk,
  input  logic         reset,
  scan_driver_if.slave host,
  output logic         scan_phi,
  output logic         scan_phi_bar,
  output logic         scan_data_in,
  input  logic         scan_data_out,
  output logic         scan_load_chain,
  output logic         scan_load_chip
);

  localparam int G        = GAP_CYC;
  localparam int P        = PHASE_CYC;
  localparam int CAP_CYC  = 3 * G + 2 * P;
  localparam int SLOT_CYC = 2 * G + 2 * P;
  localparam int UPD_CYC  = P + G;
  localparam int CYC_W    = $clog2(CAP_CYC);
  localparam int IDX_W    = (CHAIN_MAX > 1) ? $clog2(CHAIN_MAX) : 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, TAIL, UPDATE, RESP} state_t;

  state_t               state_q, state_n;
  logic [CYC_W-1:0]     cyc_q, cyc_n, cyc_inc;
  logic [IDX_W-1:0]     idx_q, idx_n, last_q, last_n;
  logic                 len_zero_q, len_zero_n;
  logic                 upd_q, upd_n;
  logic [CHAIN_MAX-1:0] wdata_q, wdata_n;
  logic [CHAIN_MAX-1:0] rdata_q, rdata_n;
  logic [LEN_W-1:0]     len_c;
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;

  logic phase_state, phi_n, phi_bar_n, data_in_n, load_chain_n, load_chip_n;

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rdata_q;

  // State, counters, data words and every pad output are registered here;
  // outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      idx_q           <= '0;
      last_q          <= '0;
      len_zero_q      <= 1'b0;
      upd_q           <= 1'b0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      scan_phi        <= 1'b0;
      scan_phi_bar    <= 1'b0;
      scan_data_in    <= 1'b0;
      scan_load_chain <= 1'b0;
      scan_load_chip  <= 1'b0;
    end else begin
      state_q         <= state_n;
      cyc_q           <= cyc_n;
      idx_q           <= idx_n;
      last_q          <= last_n;
      len_zero_q      <= len_zero_n;
      upd_q           <= upd_n;
      wdata_q         <= wdata_n;
      rdata_q         <= rdata_n;
      cmd_ready_q     <= (state_n == IDLE);
      rsp_valid_q     <= (state_n == RESP);
      scan_phi        <= phi_n;
      scan_phi_bar    <= phi_bar_n;
      scan_data_in    <= data_in_n;
      scan_load_chain <= load_chain_n;
      scan_load_chip  <= load_chip_n;
    end
  end

  // Next-state logic. cyc counts cycles inside the current state (or the
  // current shift slot); idx is the bit being shifted in SHIFT.
  always_comb begin
    state_n    = state_q;
    cyc_n      = cyc_q;
    idx_n      = idx_q;
    last_n     = last_q;
    len_zero_n = len_zero_q;
    upd_n      = upd_q;
    wdata_n    = wdata_q;
    rdata_n    = rdata_q;
    cyc_inc    = cyc_q + CYC_W'(1);
    len_c      = (host.cmd_len > LEN_W'(CHAIN_MAX)) ? LEN_W'(CHAIN_MAX) : host.cmd_len;

    case (state_q)
      IDLE: begin
        // cmd_ready is a register, so it also gates acceptance right after reset
        if (host.cmd_valid && cmd_ready_q) begin
          upd_n      = host.cmd_op[1];
          wdata_n    = host.cmd_wdata;
          len_zero_n = (len_c == '0);
          last_n     = IDX_W'(len_c - LEN_W'(1));
          rdata_n    = '0;
          cyc_n      = '0;
          idx_n      = '0;
          if (host.cmd_op[0])
            state_n = CAPTURE;
          else if (len_c == '0)
            state_n = TAIL;
          else
            state_n = SHIFT;
        end
      end
      CAPTURE: begin
        if (cyc_q == CYC_W'(CAP_CYC - 1)) begin
          cyc_n   = '0;
          state_n = len_zero_q ? TAIL : SHIFT;
        end else begin
          cyc_n = cyc_inc;
        end
      end
      SHIFT: begin
        // chain output is stable here: previous phi_bar is over, next phi not yet started
        if (cyc_q == CYC_W'(G - 1))
          rdata_n[idx_q] = scan_data_out;
        if (cyc_q == CYC_W'(SLOT_CYC - 1)) begin
          cyc_n = '0;
          if (idx_q == last_q)
            state_n = TAIL;
          else
            idx_n = idx_q + IDX_W'(1);
        end else begin
          cyc_n = cyc_inc;
        end
      end
      TAIL: begin
        if (cyc_q == CYC_W'(G - 1)) begin
          cyc_n   = '0;
          state_n = upd_q ? UPDATE : RESP;
        end else begin
          cyc_n = cyc_inc;
        end
      end
      UPDATE: begin
        if (cyc_q == CYC_W'(UPD_CYC - 1)) begin
          cyc_n   = '0;
          state_n = RESP;
        end else begin
          cyc_n = cyc_inc;
        end
      end
      RESP: begin
        if (host.rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Phase windows inside a capture sequence or a shift slot: gap, phi, gap, phi_bar
    phase_state  = (state_n == CAPTURE) || (state_n == SHIFT);
    phi_n        = phase_state && (cyc_n >= CYC_W'(G)) && (cyc_n < CYC_W'(G + P));
    phi_bar_n    = phase_state && (cyc_n >= CYC_W'(2 * G + P)) && (cyc_n < CYC_W'(SLOT_CYC));
    data_in_n    = (state_n == SHIFT) ? wdata_n[idx_n] : 1'b0;
    load_chain_n = (state_n == CAPTURE);
    load_chip_n  = (state_n == UPDATE) && (cyc_n < CYC_W'(P));
  end

endmodule
